// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller around an external simple dual-port RAM with a registered read port.
// A 2-entry output buffer hides the RAM read latency so one word can leave per cycle.
module dpram_fifo_ctrl #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          ram_we,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wdata,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_rdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam int CW    = AW + 1;
    localparam int DEPTH = 2 ** AW;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] ram_cnt;
    logic          rd_pend;
    logic [1:0]    obuf_cnt;
    logic [DW-1:0] obuf0;
    logic [DW-1:0] obuf1;

    logic          pop;
    logic          fetch;
    logic [2:0]    occ_next;
    logic [1:0]    obuf_keep;

    assign full      = (ram_cnt == CW'(DEPTH));
    assign in_ready  = !full;
    // Reset is folded in so no write strobe reaches the RAM while held in reset.
    assign ram_we    = in_valid && in_ready && rst_n;
    assign ram_waddr = wr_ptr;
    assign ram_wdata = in_data;
    assign ram_raddr = rd_ptr;

    assign out_valid = (obuf_cnt != 2'd0);
    assign out_data  = obuf0;
    assign pop       = out_valid && out_ready;

    // Words buffered or already on their way after this edge; fetch only if room remains.
    assign occ_next  = 3'(obuf_cnt) + 3'(rd_pend) - 3'(pop);
    assign fetch     = (ram_cnt != '0) && (occ_next < 3'd2);
    assign obuf_keep = obuf_cnt - 2'(pop);

    assign count = ram_cnt + CW'(rd_pend) + CW'(obuf_cnt);
    assign empty = (count == '0);

    // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            rd_pend  <= 1'b0;
            obuf_cnt <= 2'd0;
            obuf0    <= '0;
            obuf1    <= '0;
        end else begin
            if (ram_we) wr_ptr <= wr_ptr + 1'b1;
            if (fetch)  rd_ptr <= rd_ptr + 1'b1;
            rd_pend <= fetch;

            case ({ram_we, fetch})
                2'b10:   ram_cnt <= ram_cnt + 1'b1;
                2'b01:   ram_cnt <= ram_cnt - 1'b1;
                default: ram_cnt <= ram_cnt;
            endcase

            if (pop && obuf_cnt == 2'd2) obuf0 <= obuf1;
            // The arriving word lands right behind whatever survives this edge's pop.
            if (rd_pend) begin
                if (obuf_keep == 2'd0) obuf0 <= ram_rdata;
                else                   obuf1 <= ram_rdata;
            end
            obuf_cnt <= obuf_keep + 2'(rd_pend);
        end
    end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Self-checking bench for dpram_fifo_ctrl: directed scenarios plus random traffic
// against a word-queue reference model and a behavioural registered-read RAM.
module tb_dpram_fifo_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_rdata;
    logic [AW:0]   count;
    logic          full;
    logic          empty;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: held words in order, split into RAM / in-flight / output-buffer populations.
    logic [DW-1:0] q[$];
    int m_ram, m_pend, m_ob;

    logic [DW-1:0] mem [2**AW];

    always #5 clk = ~clk;

    dpram_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
        .count(count), .full(full), .empty(empty)
    );

    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        ram_rdata <= mem[ram_raddr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ram  = 0;
        m_pend = 0;
        m_ob   = 0;
    endtask

    task automatic check_outputs();
        check("count", 32'(count), 32'(q.size()));
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("full", 32'(full), 32'(m_ram == 16));
        check("out_valid", 32'(out_valid), 32'(m_ob > 0));
        if (m_ob > 0) check("out_data", 32'(out_data), 32'(q[0]));
    endtask

    // One clock cycle: called just after a falling edge, returns just after the next one.
    task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy);
        int pop, we, fetch;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        we    = (iv && m_ram != 16) ? 1 : 0;
        pop   = (ordy && m_ob > 0) ? 1 : 0;
        fetch = (m_ram != 0 && (m_ob + m_pend - pop) < 2) ? 1 : 0;
        check("in_ready", 32'(in_ready), 32'(m_ram != 16));
        check("ram_we", 32'(ram_we), 32'(we));
        @(posedge clk);
        if (pop != 0) void'(q.pop_front());
        if (we != 0) q.push_back(d);
        m_ob   = m_ob - pop + m_pend;
        m_pend = fetch;
        m_ram  = m_ram + we - fetch;
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) mem[i] = 8'hEE;
        model_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        out_ready = 1'b0;
        #1;
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // Single word: visible after write, fetch and capture edges.
        step(1'b1, 8'h11, 1'b1);
        check("lat_e1_valid", 32'(out_valid), 32'd0);
        step(1'b0, 8'h00, 1'b1);
        check("lat_e2_valid", 32'(out_valid), 32'd0);
        step(1'b0, 8'h00, 1'b1);
        check("lat_e3_valid", 32'(out_valid), 32'd1);
        check("lat_e3_data", 32'(out_data), 32'h11);
        check("lat_e3_count", 32'(count), 32'd1);
        check("lat_e3_empty", 32'(empty), 32'd0);
        step(1'b0, 8'h00, 1'b1);

        // Fill with consumer stalled: 16 in RAM plus 2 in the output buffer.
        for (int i = 0; i < 18; i++) step(1'b1, 8'(i), 1'b0);
        check("fill_count", 32'(count), 32'd18);
        check("fill_full", 32'(full), 32'd1);
        check("fill_in_ready", 32'(in_ready), 32'd0);
        check("fill_head", 32'(out_data), 32'h00);
        step(1'b1, 8'h99, 1'b0);
        check("fill_19th_count", 32'(count), 32'd18);

        // Drain: one word per cycle, in order.
        for (int i = 0; i < 18; i++) begin
            check("drain_valid", 32'(out_valid), 32'd1);
            check("drain_data", 32'(out_data), 32'(i));
            step(1'b0, 8'h00, 1'b1);
        end
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_out_valid", 32'(out_valid), 32'd0);

        // Streaming through two pointer wraps.
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'(8'h40 + i), 1'b1);
            check("stream_in_ready", 32'(in_ready), 32'd1);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
        check("stream_empty", 32'(empty), 32'd1);

        // Reset while holding 7 words.
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("pre_rst_count", 32'(count), 32'd7);
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'hA5, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_data", 32'(out_data), 32'hA5);
        check("post_rst_count", 32'(count), 32'd1);
        step(1'b0, 8'h00, 1'b1);

        // Random traffic with varying producer/consumer pressure.
        for (int i = 0; i < 10000; i++) begin
            int bias;
            bias = (i / 1000) % 3;
            step(($urandom_range(0, 3) < 3 - bias) ? 1'b1 : 1'b0,
                 8'($urandom),
                 ($urandom_range(0, 3) < 1 + bias) ? 1'b1 : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dpram_fifo_ctrl.md
DPRAM_FIFO_CTRL -- requirements
Module: dpram_fifo_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8, data width; matches the RAM word width.
REQ-002 SHALL have parameter AW, default 4, RAM address width; depth = 2**AW = 16.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  producer offers in_data.
REQ-006 SHALL have port in_ready  output  1  controller accepts; transfer when in_valid && in_ready.
REQ-007 SHALL have port in_data  input  DW  write data.
REQ-008 SHALL have port out_valid  output  1  out_data holds the oldest word.
REQ-009 SHALL have port out_ready  input  1  consumer takes word; pop when out_valid && out_ready.
REQ-010 SHALL have port out_data  output  DW  head word, registered.
REQ-011 SHALL have port ram_we  output  1  to RAM port A write enable.
REQ-012 SHALL have port ram_waddr  output  AW  to RAM port A address.
REQ-013 SHALL have port ram_wdata  output  DW  to RAM port A data.
REQ-014 SHALL have port ram_raddr  output  AW  to RAM port B address; port B write enable is tied 0 at the parent level.
REQ-015 SHALL have port ram_rdata  input  DW  from RAM port B registered output; equals mem[ram_raddr sampled at the previous edge].
REQ-016 SHALL have port count  output  AW+1  total words held (RAM + in-flight + output buffer), 0..18.
REQ-017 SHALL have ports full, empty  output  1 each  full = (ram_cnt == 16); empty = (count == 0).

Function
REQ-018 SHALL keep wr_ptr, rd_ptr (AW bits, wrap 15->0), ram_cnt (0..16), rd_pend (1 bit), obuf (2-entry FIFO, obuf_cnt 0..2).
REQ-019 SHALL drive in_ready = !full and ram_we = in_valid && in_ready, both combinational; ram_waddr = wr_ptr; ram_wdata = in_data.
REQ-020 SHALL on each write increment wr_ptr; in_valid while full is held off, no write, no state change.
REQ-021 SHALL drive ram_raddr = rd_ptr; a fetch occurs at an edge when F = (ram_cnt != 0) && (obuf_cnt + rd_pend - pop < 2).
REQ-022 SHALL on fetch increment rd_ptr and set rd_pend = 1 for the next cycle; otherwise rd_pend = 0.
REQ-023 SHALL when rd_pend = 1 push ram_rdata into obuf at the next edge, behind any older obuf entry, honouring a same-edge pop.
REQ-024 SHALL update ram_cnt by +1 on write, -1 on fetch, unchanged on simultaneous write and fetch.
REQ-025 SHALL drive out_valid = (obuf_cnt != 0); out_data = obuf head; pop removes head.
REQ-026 SHALL never fetch the location written at the same edge (guaranteed: fetch needs ram_cnt != 0, write needs ram_cnt != 16).
REQ-027 SHALL sustain one write and one pop per cycle in steady state; first write to out_valid latency = 3 edges (write, fetch, capture).
REQ-028 SHALL preserve strict FIFO order across pointer wrap-around.
REQ-029 SHALL keep count = ram_cnt + rd_pend + obuf_cnt, updated at the same edge as its components.

Reset
REQ-030 SHALL on rst_n low immediately clear wr_ptr, rd_ptr, ram_cnt, rd_pend, obuf_cnt; out_valid=0, out_data=0, count=0, empty=1, full=0, in_ready=1 after release, ram_we=0 while in reset.
REQ-031 SHALL discard all held words on reset mid-operation; RAM contents are not cleared and SHALL not reappear at the output.

Verification
REQ-032 Write 0x11 at edge 1 (out_ready=1) -> out_valid=1, out_data=0x11 after edge 3; count 1, empty=0.
REQ-033 Write 0x00..0x11 (18 words), out_ready=0 -> obuf holds 0x00,0x01; full=1 and in_ready=0 at count=18; 19th offer not written.
REQ-034 From full, out_ready=1 for 18 cycles -> outputs 0x00..0x11 in order, one per cycle, then empty=1, out_valid=0.
REQ-035 Continuous in_valid=out_ready=1 for 40 words -> pointers wrap twice, zero loss/duplication, in_ready stays 1.
REQ-036 rst_n low for 1 cycle while count=7 -> count=0, out_valid=0 immediately; next write 0xA5 emerges first, no stale data.
REQ-037 Random in_valid/out_ready 10k cycles vs scoreboard -> order exact, count matches model, no write while full.
